reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 119 +++++++++++
 tb/tb_reset_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release sequencer. It synchronizes the release of an async reset, holds all stages,
// then releases rst_out[0], rst_out[1] and rst_out[2] in order. A soft request restarts the hold.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_req,
    output logic [2:0] rst_out,
    output logic       ready
);

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        GAP1,
        GAP2,
        RUN
    } state_t;

    localparam logic [7:0] HOLD_TC = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_TC  = 8'(STAGE_GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] rst_out_q, rst_out_d;
    logic       ready_q, ready_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SYNC;
            cnt_q     <= 8'd0;
            rst_out_q <= 3'b111;
            ready_q   <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
        end
    end

    // A soft request outranks any release that would happen on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        s1_d      = 1'b1;
        s2_d      = s1_q;

        if (state_q != SYNC && sw_req) begin
            state_d   = HOLD;
            cnt_d     = 8'd0;
            rst_out_d = 3'b111;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    rst_out_d = 3'b111;
                    ready_d   = 1'b0;
                    if (s2_q) begin
                        state_d = HOLD;
                        cnt_d   = 8'd0;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = 8'd0;
                        state_d      = GAP1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                GAP1: begin
                    if (cnt_q == GAP_TC) begin
                        rst_out_d[1] = 1'b0;
                        cnt_d        = 8'd0;
                        state_d      = GAP2;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                GAP2: begin
                    if (cnt_q == GAP_TC) begin
                        rst_out_d[2] = 1'b0;
                        ready_d      = 1'b1;
                        cnt_d        = 8'd0;
                        state_d      = RUN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    rst_out_d = 3'b000;
                    ready_d   = 1'b1;
                end
                default: begin
                    state_d   = SYNC;
                    cnt_d     = 8'd0;
                    rst_out_d = 3'b111;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default timing, minimum-parameter timing, async reset abort,
// soft-reset restart and hold, and soft requests ignored while synchronizing.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       sw_a;
    logic       sw_b;
    logic [2:0] rst_a;
    logic       ready_a;
    logic [2:0] rst_b;
    logic       ready_b;

    int total_checks = 0;
    int bad_checks   = 0;

    reset_sequencer dut_a (
        .clk     (clk),
        .reset   (reset),
        .sw_req  (sw_a),
        .rst_out (rst_a),
        .ready   (ready_a)
    );

    reset_sequencer #(.HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .sw_req  (sw_b),
        .rst_out (rst_b),
        .ready   (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Expected {ready, rst_out} at edge n, where the first HOLD count happens at edge off+1.
    function automatic logic [3:0] expected_out(int n, int off, int hold, int gap);
        logic r0, r1, r2;
        r0 = (n < off + hold);
        r1 = (n < off + hold + gap);
        r2 = (n < off + hold + 2 * gap);
        return {~r2, r2, r1, r0};
    endfunction

    function automatic logic ordered(logic [2:0] r);
        return !((r[1] == 1'b0 && r[0] == 1'b1) || (r[2] == 1'b0 && r[1] == 1'b1));
    endfunction

    task automatic checkEdge(input int n, input int off, input bit with_b);
        checkOutput($sformatf("A n=%0d off=%0d", n, off), {ready_a, rst_a}, expected_out(n, off, 16, 8));
        checkOutput($sformatf("A order n=%0d", n), {3'b000, ordered(rst_a)}, 4'd1);
        if (with_b) begin
            checkOutput($sformatf("B n=%0d off=%0d", n, off), {ready_b, rst_b}, expected_out(n, off, 1, 1));
            checkOutput($sformatf("B order n=%0d", n), {3'b000, ordered(rst_b)}, 4'd1);
        end
    endtask

    task automatic applyStimulus(input int first, input int last, input int off, input bit with_b);
        for (int n = first; n <= last; n++) begin
            tick();
            checkEdge(n, off, with_b);
        end
    endtask

    initial begin
        reset = 1'b1;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("A in reset", {ready_a, rst_a}, 4'b0111);
        checkOutput("B in reset", {ready_b, rst_b}, 4'b0111);

        reset = 1'b0;
        applyStimulus(1, 22, 3, 1'b1);

        #2 reset = 1'b1;
        #1;
        checkOutput("A async abort", {ready_a, rst_a}, 4'b0111);
        checkOutput("B async abort", {ready_b, rst_b}, 4'b0111);
        #2 reset = 1'b0;
        applyStimulus(1, 40, 3, 1'b1);

        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        checkEdge(0, 0, 1'b0);
        applyStimulus(1, 28, 0, 1'b0);

        sw_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("A sw held %0d", i), {ready_a, rst_a}, 4'b0111);
        end
        sw_a = 1'b0;
        applyStimulus(1, 40, 0, 1'b0);

        reset = 1'b1;
        tick();
        checkOutput("A reset again", {ready_a, rst_a}, 4'b0111);
        reset = 1'b0;
        sw_a  = 1'b1;
        applyStimulus(1, 2, 3, 1'b1);
        sw_a = 1'b0;
        applyStimulus(3, 40, 3, 1'b1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
